// File: rtl/an_dec_sched.sv
// ---------------------------------------------------------------------------
// an_dec_sched
//   Shares one AN-code (A = 50861) single-error-correcting decoder among
//   NREQ requesters. A job is accepted from the arbitration winner, the
//   decoder is given a one-cycle clean reset, and the decoder input is then
//   held stable. The block waits for the decoder's found pulse or a timeout
//   and returns the quotient tagged with the requester index.
//
//   Build option: define AN_SCHED_RR_EN for round-robin arbitration.
//   Without it, arbitration is fixed priority (lowest index wins) and no
//   priority pointer register exists.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   req_valid    in   [NREQ]          per-requester request
//   req_w        in   [NREQ*W_BITS]   codewords, requester i at [i*W_BITS +: W_BITS]
//   req_ready    out  [NREQ]          one-hot grant (combinational, IDLE only)
//   resp_valid   out                  result available
//   resp_ready   in                   consumer accepts result
//   resp_n       out  [N_BITS]        decoded quotient (0 on timeout)
//   resp_id      out  [ID_BITS]       owning requester index
//   resp_timeout out                  job abandoned after TIMEOUT WAIT cycles
//   dec_rst_n    out                  active-low decoder reset (high only in WAIT)
//   dec_w        out  [W_BITS]        codeword driven to the decoder
//   dec_found    in                   decoder done pulse
//   dec_n        in   [N_BITS]        decoder result, valid with dec_found
// ---------------------------------------------------------------------------
module an_dec_sched #(
  parameter int NREQ    = 4,
  parameter int W_BITS  = 69,
  parameter int N_BITS  = 53,
  parameter int ID_BITS = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W_BITS-1:0]   req_w,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [N_BITS-1:0]        resp_n,
  output logic [ID_BITS-1:0]       resp_id,
  output logic                     resp_timeout,
  output logic                     dec_rst_n,
  output logic [W_BITS-1:0]        dec_w,
  input  logic                     dec_found,
  input  logic [N_BITS-1:0]        dec_n
);

  localparam int CNT_BITS = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_resp_valid;
  logic [N_BITS-1:0]   r_resp_n;
  logic [ID_BITS-1:0]  r_resp_id;
  logic                r_resp_timeout;
  logic                r_dec_rst_n;
  logic [W_BITS-1:0]   r_dec_w;

  logic [ID_BITS-1:0]  w_base;
  logic [2*NREQ-1:0]   w_rot2;
  logic [NREQ-1:0]     w_grant;
  logic [ID_BITS-1:0]  w_grant_id;
  logic                w_any;
  int                  w_sum;
  logic                w_hs;

`ifdef AN_SCHED_RR_EN
  logic [ID_BITS-1:0]  r_ptr;
  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  // Arbitration: rotate the request vector so the highest-priority index
  // lands at bit 0, take the first set bit, then map back to the real index.
  always_comb begin
    w_rot2     = {req_valid, req_valid} >> w_base;
    w_any      = 1'b0;
    w_grant_id = '0;
    w_sum      = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && w_rot2[k]) begin
        w_any = 1'b1;
        w_sum = int'(w_base) + k;
        if (w_sum >= NREQ) begin
          w_sum = w_sum - NREQ;
        end else begin
          w_sum = w_sum;
        end
        w_grant_id = ID_BITS'(w_sum);
      end else begin
        w_any = w_any;
      end
    end
    if (w_any) begin
      w_grant = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_id;
    end else begin
      w_grant = '0;
    end
  end

  // Grants are only offered in IDLE and are suppressed while rst is high.
  assign req_ready = (r_state == S_IDLE && !rst) ? w_grant : '0;
  assign w_hs      = |req_ready;

  // Main job FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_n       <= '0;
      r_resp_id      <= '0;
      r_resp_timeout <= 1'b0;
      r_dec_rst_n    <= 1'b0;
      r_dec_w        <= '0;
`ifdef AN_SCHED_RR_EN
      r_ptr          <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_dec_w   <= req_w[w_grant_id*W_BITS +: W_BITS];
            r_resp_id <= w_grant_id;
`ifdef AN_SCHED_RR_EN
            r_ptr     <= (w_grant_id == ID_BITS'(NREQ-1)) ? '0 : w_grant_id + ID_BITS'(1);
`endif
            r_state   <= S_LAUNCH;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        // One cycle of decoder reset flushes any stale iteration; found is
        // ignored here.
        S_LAUNCH: begin
          r_cnt       <= '0;
          r_dec_rst_n <= 1'b1;
          r_state     <= S_WAIT;
        end
        // found wins over a coincident timeout.
        S_WAIT: begin
          if (dec_found) begin
            r_resp_n       <= dec_n;
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_dec_rst_n    <= 1'b0;
            r_state        <= S_RESP;
          end else if (r_cnt == CNT_BITS'(TIMEOUT-1)) begin
            r_resp_n       <= '0;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_dec_rst_n    <= 1'b0;
            r_state        <= S_RESP;
          end else begin
            r_cnt          <= r_cnt + CNT_BITS'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_state      <= S_RESP;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_dec_rst_n  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_n       = r_resp_n;
  assign resp_id      = r_resp_id;
  assign resp_timeout = r_resp_timeout;
  assign dec_rst_n    = r_dec_rst_n;
  assign dec_w        = r_dec_w;

endmodule

// File: tb/tb_an_dec_sched.sv
// Testbench for an_dec_sched with a behavioural stand-in for the AN decoder:
// it pulses found on the 5th cycle after its reset is released (matching the
// error-free decoder latency) and returns round(W / 50861).
module tb_an_dec_sched;
  localparam int NREQ = 4;
  localparam int WB   = 69;
  localparam int NB   = 53;
  localparam int IDB  = 2;
  localparam int TMO  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*WB-1:0]   req_w;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [NB-1:0]        resp_n;
  logic [IDB-1:0]       resp_id;
  logic                 resp_timeout;
  logic                 dec_rst_n;
  logic [WB-1:0]        dec_w;
  logic                 dec_found;
  logic [NB-1:0]        dec_n;

  int n_tests = 0;
  int n_fail  = 0;

  an_dec_sched #(.NREQ(NREQ), .W_BITS(WB), .N_BITS(NB), .ID_BITS(IDB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_w(req_w), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_n(resp_n), .resp_id(resp_id),
    .resp_timeout(resp_timeout), .dec_rst_n(dec_rst_n), .dec_w(dec_w),
    .dec_found(dec_found), .dec_n(dec_n)
  );

  always #5 clk = ~clk;

  // Decoder stand-in.
  logic [7:0]  stub_cnt = 8'd0;
  logic        stub_silent = 1'b0;
  logic [68:0] stub_q;
  always @(posedge clk) begin
    if (dec_rst_n !== 1'b1) stub_cnt <= 8'd0;
    else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
  end
  assign dec_found = (dec_rst_n === 1'b1) && (stub_cnt == 8'd4) && !stub_silent;
  assign stub_q    = (dec_w + 69'd25430) / 69'd50861;
  assign dec_n     = dec_found ? stub_q[52:0] : 53'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, clocks the handshake edge and returns edges to resp_valid.
  task automatic run_job(input int idx, input logic [WB-1:0] w, input int budget,
                         output int lat, output bit stable, output bit rstn_hi);
    logic [WB-1:0] w0;
    req_w[idx*WB +: WB] = w;
    req_valid = 4'b0001 << idx;
    #1;
    n_tests++;
    if (req_ready !== (4'b0001 << idx)) begin
      n_fail++; $display("FAIL grant_req%0d: got %b want %b", idx, req_ready, 4'b0001 << idx);
    end
    tick();
    req_valid = 4'b0000;
    n_tests++;
    if (dec_rst_n !== 1'b0 || dec_w !== w) begin
      n_fail++; $display("FAIL launch: dec_rst_n=%b dec_w=%0d want 0/%0d", dec_rst_n, dec_w, w);
    end
    w0 = dec_w; lat = 0; stable = 1'b1; rstn_hi = 1'b1;
    while (resp_valid !== 1'b1 && lat < budget) begin
      tick();
      lat++;
      if (dec_w !== w0) stable = 1'b0;
      if (resp_valid !== 1'b1 && dec_rst_n !== 1'b1) rstn_hi = 1'b0;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || dec_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL resp_release: resp_valid=%b dec_rst_n=%b want 0/0", resp_valid, dec_rst_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_w = '0; resp_ready = 1'b0;
    tick(); tick();
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    n_tests++;
    if (resp_valid !== 1'b0 || resp_n !== '0 || resp_id !== '0 || resp_timeout !== 1'b0 ||
        dec_rst_n !== 1'b0 || dec_w !== '0) begin
      n_fail++; $display("FAIL reset_outputs: v=%b n=%0d id=%0d to=%b rn=%b w=%0d want all 0",
                         resp_valid, resp_n, resp_id, resp_timeout, dec_rst_n, dec_w);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_decode();
    int lat; bit st; bit hi;
    run_job(2, 69'd50861000, 40, lat, st, hi);
    n_tests++;
    if (lat !== 6) begin n_fail++; $display("FAIL clean_latency: got %0d want 6", lat); end
    n_tests++;
    if (resp_n !== 53'd1000 || resp_id !== 2'd2 || resp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL clean_result: n=%0d id=%0d to=%b want 1000/2/0", resp_n, resp_id, resp_timeout);
    end
    n_tests++;
    if (!hi) begin n_fail++; $display("FAIL clean_dec_rst_n: got low in WAIT want 1"); end
    finish_resp();
  endtask

  task automatic test_single_error();
    int lat; bit st; bit hi;
    run_job(0, 69'd50861004, 40, lat, st, hi);
    n_tests++;
    if (lat !== 6 || resp_n !== 53'd1000 || resp_id !== 2'd0 || resp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL err_result: lat=%0d n=%0d id=%0d to=%b want 6/1000/0/0", lat, resp_n, resp_id, resp_timeout);
    end
    n_tests++;
    if (!st) begin n_fail++; $display("FAIL err_dec_w_stable: got changing want stable"); end
    finish_resp();
  endtask

  task automatic test_timeout();
    int lat; bit st; bit hi;
    stub_silent = 1'b1;
    run_job(1, 69'd50861123, 60, lat, st, hi);
    stub_silent = 1'b0;
    n_tests++;
    if (lat !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d want 17", lat); end
    n_tests++;
    if (resp_timeout !== 1'b1 || resp_n !== 53'd0 || resp_id !== 2'd1) begin
      n_fail++; $display("FAIL timeout_result: to=%b n=%0d id=%0d want 1/0/1", resp_timeout, resp_n, resp_id);
    end
    n_tests++;
    if (!hi) begin n_fail++; $display("FAIL timeout_dec_rst_n: got low in WAIT want 1"); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    int lat; bit st; bit hi; bit ok;
    run_job(3, 69'd25430500, 40, lat, st, hi);
    req_valid = 4'b1111;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_n !== 53'd500 || resp_id !== 2'd3 ||
          req_ready !== 4'b0000 || dec_rst_n !== 1'b0) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_hold: v=%b n=%0d id=%0d rdy=%b rn=%b want 1/500/3/0000/0",
                         resp_valid, resp_n, resp_id, req_ready, dec_rst_n);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // Pointer sits at 0 after granting 3, so both builds offer requester 0.
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_turnaround: v=%b rdy=%b want 0/0001", resp_valid, req_ready);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_arbitration();
    int exp_ids[5];
    int n_grants;
    int gid;
    int c;
`ifdef AN_SCHED_RR_EN
    exp_ids = '{0, 1, 2, 3, 0}; n_grants = 5;
`else
    exp_ids = '{0, 0, 0, 0, 0}; n_grants = 3;
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_w[i*WB +: WB] = 69'(50861 * (10 + i));
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int g = 0; g < n_grants; g++) begin
      c = 0;
      while (req_ready === 4'b0000 && c < 30) begin tick(); c++; end
      gid = -1;
      for (int b = 0; b < NREQ; b++) if (req_ready[b]) gid = b;
      n_tests++;
      if (gid !== exp_ids[g] || $countones(req_ready) != 1) begin
        n_fail++; $display("FAIL arb_grant%0d: got %b want index %0d", g, req_ready, exp_ids[g]);
      end
      tick();
      c = 0;
      while (resp_valid !== 1'b1 && c < 30) begin tick(); c++; end
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== IDB'(exp_ids[g]) || resp_n !== NB'(10 + exp_ids[g])) begin
        n_fail++; $display("FAIL arb_resp%0d: v=%b id=%0d n=%0d want 1/%0d/%0d",
                           g, resp_valid, resp_id, resp_n, exp_ids[g], 10 + exp_ids[g]);
      end
      tick();
    end
    req_valid = 4'b0000;
    resp_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_wait();
    int lat; bit st; bit hi; bit quiet;
    req_w[3*WB +: WB] = 69'd50861999;
    req_valid = 4'b1000;
    tick();                      // E0 handshake
    req_valid = 4'b0000;
    tick(); tick(); tick();      // E1..E3, now in WAIT cycle 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || resp_n !== '0 || resp_id !== '0 || resp_timeout !== 1'b0 ||
        dec_rst_n !== 1'b0 || dec_w !== '0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_outputs: v=%b n=%0d id=%0d to=%b rn=%b w=%0d rdy=%b want all 0",
                         resp_valid, resp_n, resp_id, resp_timeout, dec_rst_n, dec_w, req_ready);
    end
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (resp_valid !== 1'b0 || dec_rst_n !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin n_fail++; $display("FAIL midrst_no_resp: got activity want none"); end
    run_job(1, 69'd3916297, 40, lat, st, hi);   // 50861 * 77
    n_tests++;
    if (lat !== 6 || resp_n !== 53'd77 || resp_id !== 2'd1 || resp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_next_job: lat=%0d n=%0d id=%0d to=%b want 6/77/1/0",
                         lat, resp_n, resp_id, resp_timeout);
    end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_clean_decode();
    test_single_error();
    test_timeout();
    test_backpressure();
    test_arbitration();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
